// File: rtl/crc.sv
// Byte-serial CRC-16/MODBUS accumulator: absorbs one byte per enabled clock, result visible the next cycle.
// No backpressure: crc_en may be held high for back-to-back bytes; crc_en low holds the register.
module crc #(
    parameter logic [15:0] POLY = 16'hA001,
    parameter logic [15:0] INIT = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_in,
    input  logic        crc_en,
    output logic [15:0] crc_out
);

    logic [15:0] c;

    // Eight LSB-first shift/XOR stages unrolled so a whole byte lands in one clock.
    function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic [7:0] d);
        logic [15:0] t;
        t = cur ^ {8'h00, d};
        for (int i = 0; i < 8; i++) begin
            t = t[0] ? ((t >> 1) ^ POLY) : (t >> 1);
        end
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            c <= INIT;
        end else if (crc_en) begin
            c <= crc_step(c, data_in);
        end
    end

    assign crc_out = c;

endmodule

// File: tb/tb_crc.sv
// Randomized and directed check of crc against a table-driven CRC-16/MODBUS reference.
module tb_crc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  data_in;
    logic        crc_en;
    logic [15:0] crc_out;

    int total = 0;
    int bad   = 0;

    logic [15:0] mdl;
    logic [15:0] tbl [256];
    logic [7:0]  bq [$];

    crc dut (
        .clk     (clk),
        .rst     (rst),
        .data_in (data_in),
        .crc_en  (crc_en),
        .crc_out (crc_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%04h want=%04h", tag, got, exp);
        end
    endtask

    // Byte-at-a-time table lookup, the classic software formulation of this CRC.
    function automatic logic [15:0] mdl_byte(input logic [15:0] cur, input logic [7:0] d);
        logic [7:0] idx;
        idx = cur[7:0] ^ d;
        return (cur >> 8) ^ tbl[idx];
    endfunction

    task automatic step(input logic r, input logic en, input logic [7:0] d, input string tag);
        @(negedge clk);
        rst     = r;
        crc_en  = en;
        data_in = d;
        @(posedge clk);
        if (!r)       mdl = 16'hFFFF;
        else if (en)  mdl = mdl_byte(mdl, d);
        #1;
        chk(tag, crc_out, mdl);
    endtask

    // Feeds bq with random idle gaps of 0..maxgap cycles after each byte.
    task automatic feed(input int maxgap, input string tag);
        logic [15:0] held;
        int gap;
        foreach (bq[i]) begin
            step(1'b1, 1'b1, bq[i], tag);
            held = crc_out;
            gap  = (maxgap == 0) ? 0 : $urandom_range(0, maxgap);
            for (int g = 0; g < gap; g++) begin
                step(1'b1, 1'b0, 8'($urandom), {tag, "_gap"});
                chk({tag, "_hold"}, crc_out, held);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            logic [15:0] t;
            t = 16'(i);
            for (int b = 0; b < 8; b++) t = t[0] ? ((t >> 1) ^ 16'hA001) : (t >> 1);
            tbl[i] = t;
        end
        mdl = 16'hFFFF;

        // Reset overrides enable; then idle hold.
        step(1'b0, 1'b1, 8'hAA, "reset");
        chk("reset_init", crc_out, 16'hFFFF);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 8'h00, "idle");
            chk("idle_init", crc_out, 16'hFFFF);
        end

        bq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        feed(0, "modbus");
        chk("modbus_crc", crc_out, 16'h0A84);
        chk("wire_byte0", {8'h00, crc_out[7:0]}, 16'h0084);
        chk("wire_byte1", {8'h00, crc_out[15:8]}, 16'h000A);

        step(1'b0, 1'b0, 8'h00, "clr");
        bq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        feed(0, "check");
        chk("check_crc", crc_out, 16'h4B37);

        step(1'b0, 1'b0, 8'h00, "clr");
        bq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01, 8'h84, 8'h0A};
        feed(0, "residue");
        chk("residue_zero", crc_out, 16'h0000);

        step(1'b0, 1'b0, 8'h00, "clr");
        bq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        feed(3, "gaps");
        chk("gaps_crc", crc_out, 16'h0A84);

        step(1'b0, 1'b0, 8'h00, "clr");
        bq = '{8'h01, 8'h03};
        feed(0, "pre");
        step(1'b0, 1'b1, 8'h55, "midrst");
        chk("midrst_init", crc_out, 16'hFFFF);
        bq = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};
        feed(0, "post");
        chk("midrst_crc", crc_out, 16'h0A84);

        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 19) != 0), 1'($urandom), 8'($urandom), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
